// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// ALU operation classes, operand selects and trap causes.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_req_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_controller_watchdog.sv
// Memory-wait watchdog: counts consecutive unready request cycles and flags the
// TIMEOUT-th one so the controller can trap on the following edge.
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_active,
    input  logic mem_ready,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout = req_active && !mem_ready && (cnt_q == LAST);

    // Idle cycles hold the count at zero, so every request state is entered cleared.
    always_comb begin
        cnt_d = '0;
        if (req_active && !mem_ready && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory multi-cycle RV32I datapath, with memory
// watchdog, sticky trap and retired-instruction counter.
//
// state       | meaning
// S_FETCH     | read instruction at PC, PC += 4 on ready
// S_DECODE    | branch target into ALUOut, dispatch on opcode
// S_EXEC_R    | rs1 op rs2
// S_EXEC_I    | rs1 op imm
// S_ALU_WB    | write ALUOut to rd, retire
// S_MEM_ADDR  | rs1 + imm into ALUOut
// S_MEM_READ  | load request at ALUOut
// S_MEM_WB    | write loaded data to rd, retire
// S_MEM_WRITE | store request at ALUOut, retire on ready
// S_BRANCH    | compare rs1/rs2, conditional PC load, retire
// S_TRAP      | halted until reset
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    state_e           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             timeout;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .req_active (is_req_state(state_q)),
        .mem_ready  (mem_ready),
        .timeout    (timeout)
    );

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        result_src = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        retire     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    pc_write = (funct3 == F3_BEQ) ? zero : !zero;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset mid-request must not leave any side effect on memory or state.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

    assign instret_d = retire ? instret_q + 1'b1 : instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle decode vectors, instruction-level
// reference model under random memory latency, and hand-written corner sequences.
module tb_multicycle_controller;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             zero;
    logic             mem_ready;
    logic             mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic             reg_write, result_src, retire, trap;
    logic [1:0]       alu_src_a, alu_src_b, alu_op, trap_cause;
    logic [CNT_W-1:0] instret;

    multicycle_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .retire     (retire),
        .instret    (instret),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        logic        rdy;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   model_instret = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] o(input logic req, we, io, irw, pcw, pcs, rw, rs,
                                      input logic [1:0] a, b, op, input logic ret);
        return {req, we, io, irw, pcw, pcs, rw, rs, a, b, op, ret};
    endfunction

    function automatic logic [14:0] dut_out();
        return {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, result_src,
                alu_src_a, alu_src_b, alu_op, retire};
    endfunction

    task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input logic rdy, input logic [14:0] exp);
        vec_t v;
        v.op = op; v.f3 = f3; v.z = z; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_strobes", {mem_req, mem_we, ir_write, pc_write, reg_write, retire}, 0);
            tick();
        end
        rst = 1'b0;
        model_instret = 0;
    endtask

    // Instruction-level model: latency = base CPI + injected wait cycles; effects
    // counted over the whole instruction rather than per state.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int df, input int dm);
        int  cyc = 0, unready = 0, reqi = 0;
        int  regw = 0, pcw = 0, we_cyc = 0, data_cyc = 0, rs_bad = 0;
        int  exp_cyc, exp_regw, exp_pcw, exp_data, d;
        bit  done = 0;
        bit  is_mem = (op == OP_LOAD) || (op == OP_STORE);
        bit  taken = (f3 == 3'b000) ? z : !z;

        exp_cyc  = (op == OP_LOAD) ? 5 : (op == OP_BRANCH) ? 3 : 4;
        exp_cyc  = exp_cyc + df + (is_mem ? dm : 0);
        exp_regw = (op == OP_STORE || op == OP_BRANCH) ? 0 : 1;
        exp_pcw  = 1 + ((op == OP_BRANCH && taken) ? 1 : 0);
        exp_data = is_mem ? dm + 1 : 0;

        opcode = op; funct3 = f3; zero = z;
        while (!done && cyc < 64) begin
            if (mem_req) begin
                d = (reqi == 0) ? df : dm;
                if (unready < d) begin
                    mem_ready = 1'b0;
                    unready++;
                end else begin
                    mem_ready = 1'b1;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
            if (reg_write) begin
                regw++;
                if (result_src !== (op == OP_LOAD)) rs_bad++;
            end
            if (pc_write) pcw++;
            if (mem_we) we_cyc++;
            if (mem_req && iord) data_cyc++;
            if (mem_req && mem_ready) begin
                reqi++;
                unready = 0;
            end
            if (retire) done = 1;
            tick();
        end
        model_instret++;
        chk("instr_cycles", cyc, exp_cyc);
        chk("instr_reg_write", regw, exp_regw);
        chk("instr_pc_write", pcw, exp_pcw);
        chk("instr_mem_we", we_cyc, (op == OP_STORE) ? dm + 1 : 0);
        chk("instr_data_req", data_cyc, exp_data);
        chk("instr_result_src", rs_bad, 0);
        chk("instr_instret", instret, model_instret);
        chk("instr_no_trap", trap, 0);
    endtask

    initial begin
        add_vec(OP_R, 0, 0, 0, o(1,0,0,0,0,0,0,0, 0,2,0, 0));
        add_vec(OP_R, 0, 0, 1, o(1,0,0,1,1,0,0,0, 0,2,0, 0));
        add_vec(OP_R, 0, 0, 1, o(0,0,0,0,0,0,0,0, 1,1,0, 0));
        add_vec(OP_R, 0, 0, 1, o(0,0,0,0,0,0,0,0, 2,0,2, 0));
        add_vec(OP_R, 0, 0, 1, o(0,0,0,0,0,0,1,0, 0,0,0, 1));
        add_vec(OP_I, 0, 0, 1, o(1,0,0,1,1,0,0,0, 0,2,0, 0));
        add_vec(OP_I, 0, 0, 1, o(0,0,0,0,0,0,0,0, 1,1,0, 0));
        add_vec(OP_I, 0, 0, 1, o(0,0,0,0,0,0,0,0, 2,1,2, 0));
        add_vec(OP_I, 0, 0, 1, o(0,0,0,0,0,0,1,0, 0,0,0, 1));
        add_vec(OP_LOAD, 2, 0, 1, o(1,0,0,1,1,0,0,0, 0,2,0, 0));
        add_vec(OP_LOAD, 2, 0, 1, o(0,0,0,0,0,0,0,0, 1,1,0, 0));
        add_vec(OP_LOAD, 2, 0, 1, o(0,0,0,0,0,0,0,0, 2,1,0, 0));
        add_vec(OP_LOAD, 2, 0, 1, o(1,0,1,0,0,0,0,0, 0,0,0, 0));
        add_vec(OP_LOAD, 2, 0, 1, o(0,0,0,0,0,0,1,1, 0,0,0, 1));
        add_vec(OP_STORE, 2, 0, 1, o(1,0,0,1,1,0,0,0, 0,2,0, 0));
        add_vec(OP_STORE, 2, 0, 1, o(0,0,0,0,0,0,0,0, 1,1,0, 0));
        add_vec(OP_STORE, 2, 0, 1, o(0,0,0,0,0,0,0,0, 2,1,0, 0));
        add_vec(OP_STORE, 2, 0, 1, o(1,1,1,0,0,0,0,0, 0,0,0, 1));
        add_vec(OP_BRANCH, 0, 1, 1, o(1,0,0,1,1,0,0,0, 0,2,0, 0));
        add_vec(OP_BRANCH, 0, 1, 1, o(0,0,0,0,0,0,0,0, 1,1,0, 0));
        add_vec(OP_BRANCH, 0, 1, 1, o(0,0,0,0,1,1,0,0, 2,0,1, 1));
        add_vec(OP_BRANCH, 1, 1, 1, o(1,0,0,1,1,0,0,0, 0,2,0, 0));
        add_vec(OP_BRANCH, 1, 1, 1, o(0,0,0,0,0,0,0,0, 1,1,0, 0));
        add_vec(OP_BRANCH, 1, 1, 1, o(0,0,0,0,0,1,0,0, 2,0,1, 1));

        opcode = OP_R; funct3 = 0; zero = 0; mem_ready = 0; rst = 1;
        do_reset();

        @(negedge clk);
        chk("reset_instret", instret, 0);
        chk("reset_trap", {trap, trap_cause}, 0);
        chk("reset_fetch_req", {mem_req, alu_src_b}, {1'b1, 2'd2});
        tick();

        foreach (vecs[i]) begin
            opcode = vecs[i].op; funct3 = vecs[i].f3; zero = vecs[i].z; mem_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
            tick();
        end
        chk("vec_instret", instret, 6);
        model_instret = 6;

        run_instr(OP_R, 3'd0, 0, 0, 0);
        run_instr(OP_LOAD, 3'd2, 0, 0, 3);
        run_instr(OP_BRANCH, 3'd0, 1, 0, 0);
        run_instr(OP_BRANCH, 3'd0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int        kind = $urandom_range(0, 5);
            logic [6:0] op;
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            case (kind)
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LOAD;
                3: op = OP_STORE;
                default: begin
                    op = OP_BRANCH;
                    f3 = (kind == 4) ? 3'd0 : 3'd1;
                end
            endcase
            run_instr(op, f3, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Reset while a store waits for memory: nothing may complete.
        opcode = OP_STORE; funct3 = 3'd2; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("sw_wait_req", {mem_req, mem_we, iord}, 3'b111);
        tick();
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("sw_rst_strobes", {mem_req, mem_we, ir_write, pc_write, reg_write, retire}, 0);
        tick();
        rst = 1'b0; mem_ready = 1'b0; model_instret = 0;
        @(negedge clk);
        chk("sw_rst_instret", instret, 0);
        chk("sw_rst_fetch", {mem_req, mem_we, alu_src_b}, {1'b1, 1'b0, 2'd2});
        tick();

        do_reset();
        opcode = OP_R; mem_ready = 1'b0;
        repeat (TIMEOUT - 1) tick();
        @(negedge clk);
        chk("wd_before_trap", {trap, mem_req}, 2'b01);
        tick();
        @(negedge clk);
        chk("wd_trap", {trap, trap_cause}, {1'b1, 2'd2});
        chk("wd_trap_quiet", mem_req, 0);

        do_reset();
        mem_ready = 1'b0;
        repeat (TIMEOUT - 1) tick();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("wd_ready_last", ir_write, 1);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("wd_no_trap", {trap, trap_cause}, 0);
        tick();

        do_reset();
        opcode = 7'b1111111; mem_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("ill_op_trap", {trap, trap_cause}, {1'b1, 2'd1});
        begin
            int reqs = 0;
            for (int k = 0; k < 6; k++) begin
                mem_ready = 1'($urandom_range(0, 1));
                tick();
                @(negedge clk);
                if (mem_req || retire) reqs++;
            end
            chk("ill_op_quiet", reqs, 0);
            chk("ill_op_sticky", {trap, trap_cause}, {1'b1, 2'd1});
        end
        tick();

        do_reset();
        chk("rst_clears_trap", {trap, trap_cause}, 0);
        opcode = OP_BRANCH; funct3 = 3'b010; zero = 1'b1; mem_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("ill_f3_no_effect", {pc_write, retire}, 0);
        tick();
        @(negedge clk);
        chk("ill_f3_trap", {trap, trap_cause}, {1'b1, 2'd1});
        chk("ill_f3_instret", instret, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
